// File: rtl/interleave_block_input_vector_pkg.sv
// Shared types and helpers for the block-to-interleave reorder stage.
// Defaults describe the reference configuration; the top derives its own sizes.
package interleave_pkg;

  localparam int IIR_DEFAULT = 3;
  localparam int N_DEFAULT   = 10;
  localparam int DEPTH       = IIR_DEFAULT * N_DEFAULT;
  localparam int AW          = $clog2(2 * DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Linear word address inside the ping-pong RAM: bank, then channel, then sample.
  function automatic int addr_of(input int bank, input int ch, input int idx,
                                 input int n, input int depth);
    return bank * depth + ch * n + idx;
  endfunction

endpackage

// File: rtl/interleave_block_input_vector_if.sv
// Sample bus of the interleaver: block-ordered input, interleaved output with channel tags.
interface interleave_block_input_vector_if #(
  parameter int BITS = 8,
  parameter int V    = 2,
  parameter int CHW  = 2
);
  logic            in_valid;
  logic [BITS-1:0] data_in [V];
  logic            out_valid;
  logic [BITS-1:0] data_out [V];
  logic [CHW-1:0]  out_ch;
  logic            out_first;

  modport master (
    output in_valid, data_in,
    input  out_valid, data_out, out_ch, out_first
  );

  modport slave (
    input  in_valid, data_in,
    output out_valid, data_out, out_ch, out_first
  );
endinterface

// File: rtl/interleave_block_input_vector_ram.sv
// One-write one-read RAM with a registered read port that holds when re is low.
module simple_dual_port_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 60,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/interleave_block_input_vector.sv
// Reorders block-ordered samples (N per channel) into a channel-interleaved stream
// through a per-lane ping-pong RAM; counters, full flags and reader FSM are shared.
module interleave_block_input_vector
  import interleave_pkg::*;
#(
  parameter int BITS = 8,
  parameter int IIR  = 3,
  parameter int N    = 10,
  parameter int V    = 2
) (
  input logic clk,
  input logic rst_n,
  interleave_block_input_vector_if.slave bus
);
  localparam int BANK_DEPTH = IIR * N;
  localparam int ADDR_W     = (2 * BANK_DEPTH > 1) ? $clog2(2 * BANK_DEPTH) : 1;
  localparam int CH_W       = (IIR > 1) ? $clog2(IIR) : 1;
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_READ = READ;

  logic [IDX_W-1:0]  w_idx_reg;
  logic [CH_W-1:0]   w_ch_reg;
  logic              wb_reg;
  logic [1:0]        full_reg;
  logic [1:0]        full_next;
  logic [0:0]        state_reg;
  logic              rb_reg;
  logic [CH_W-1:0]   r_ch_reg;
  logic [IDX_W-1:0]  r_idx_reg;
  logic              out_valid_reg;
  logic              out_first_reg;
  logic [CH_W-1:0]   out_ch_reg;

  logic              w_idx_last, w_ch_last, r_idx_last, r_ch_last;
  logic              set_full, clr_full, rd_en;
  logic [ADDR_W-1:0] waddr, raddr;

  assign w_idx_last = (w_idx_reg == IDX_W'(N - 1));
  assign w_ch_last  = (w_ch_reg == CH_W'(IIR - 1));
  assign r_idx_last = (r_idx_reg == IDX_W'(N - 1));
  assign r_ch_last  = (r_ch_reg == CH_W'(IIR - 1));

  assign rd_en    = (state_reg == S_READ);
  assign set_full = bus.in_valid && w_idx_last && w_ch_last;
  assign clr_full = rd_en && r_idx_last && r_ch_last;

  assign waddr = ADDR_W'(addr_of(int'(wb_reg), int'(w_ch_reg), int'(w_idx_reg), N, BANK_DEPTH));
  assign raddr = ADDR_W'(addr_of(int'(rb_reg), int'(r_ch_reg), int'(r_idx_reg), N, BANK_DEPTH));

  // Write side: sample index runs fastest, channel next, bank flips per block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx_reg <= '0;
      w_ch_reg  <= '0;
      wb_reg    <= 1'b0;
    end else if (bus.in_valid) begin
      if (w_idx_last) begin
        w_idx_reg <= '0;
        if (w_ch_last) begin
          w_ch_reg <= '0;
          wb_reg   <= ~wb_reg;
        end else begin
          w_ch_reg <= w_ch_reg + 1'b1;
        end
      end else begin
        w_idx_reg <= w_idx_reg + 1'b1;
      end
    end
  end

  // Writer and reader always sit on different banks, so set and clear never collide.
  always_comb begin
    full_next = full_reg;
    if (set_full) full_next[wb_reg] = 1'b1;
    if (clr_full) full_next[rb_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 2'b00;
    end else begin
      full_reg <= full_next;
    end
  end

  // Reader: channel runs fastest; chains directly into the other bank if it is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      rb_reg    <= 1'b0;
      r_ch_reg  <= '0;
      r_idx_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|full_reg) state_reg <= S_READ;
        end
        S_READ: begin
          if (r_ch_last) begin
            r_ch_reg <= '0;
            if (r_idx_last) begin
              r_idx_reg <= '0;
              rb_reg    <= ~rb_reg;
              state_reg <= full_reg[~rb_reg] ? S_READ : S_IDLE;
            end else begin
              r_idx_reg <= r_idx_reg + 1'b1;
            end
          end else begin
            r_ch_reg <= r_ch_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Sideband delayed one stage to line up with the registered RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_ch_reg    <= '0;
    end else begin
      out_valid_reg <= rd_en;
      out_first_reg <= rd_en && (r_ch_reg == '0) && (r_idx_reg == '0);
      if (rd_en) out_ch_reg <= r_ch_reg;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_ch    = out_ch_reg;

  for (genvar gi = 0; gi < V; gi++) begin : g_lane
    simple_dual_port_ram #(
      .WIDTH (BITS),
      .DEPTH (2 * BANK_DEPTH),
      .AW    (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.in_valid),
      .waddr (waddr),
      .wdata (bus.data_in[gi]),
      .re    (rd_en),
      .raddr (raddr),
      .rdata (bus.data_out[gi])
    );
  end

  no_overwrite_of_full_bank : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_valid && (w_idx_reg == '0) && (w_ch_reg == '0) && full_reg[wb_reg]));

endmodule

// File: tb/tb_interleave_block_input_vector.sv
// Scoreboard bench: expected interleaved words are queued at stimulus time and
// popped by an independent monitor whenever out_valid is high.
module tb_interleave_block_input_vector;

  typedef struct {
    int l0;
    int l1;
    int ch;
    int first;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   runs[$];

  always #5 clk = ~clk;

  interleave_block_input_vector_if #(.BITS(8), .V(2), .CHW(2)) bus0 ();
  interleave_block_input_vector_if #(.BITS(8), .V(1), .CHW(1)) bus1 ();
  interleave_block_input_vector_if #(.BITS(8), .V(1), .CHW(2)) bus2 ();

  interleave_block_input_vector #(.BITS(8), .IIR(3), .N(10), .V(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  interleave_block_input_vector #(.BITS(8), .IIR(1), .N(4), .V(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  interleave_block_input_vector #(.BITS(8), .IIR(4), .N(1), .V(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Drives count samples of one block on dut0 (ch*16+idx on lane0, inverse on lane1).
  task automatic send_block(input int base, input bit gappy, input int count, input bit push);
    exp_t e;
    int   v;
    if (push) begin
      for (int idx = 0; idx < 10; idx++) begin
        for (int ch = 0; ch < 3; ch++) begin
          e.l0    = (base + ch * 16 + idx) & 8'hFF;
          e.l1    = (~(base + ch * 16 + idx)) & 8'hFF;
          e.ch    = ch;
          e.first = (idx == 0 && ch == 0) ? 1 : 0;
          exp_q.push_back(e);
        end
      end
    end
    for (int k = 0; k < count; k++) begin
      v = base + (k / 10) * 16 + (k % 10);
      @(negedge clk);
      bus0.in_valid   = 1'b1;
      bus0.data_in[0] = 8'(v);
      bus0.data_in[1] = ~8'(v);
      if (gappy) begin
        @(negedge clk);
        bus0.in_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus0.out_valid) break;
    end
    if (exp_q.size() != 0 || bus0.out_valid) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_run(input string name, input int want);
    if (runs.size() == 0) chk({name, "_missing"}, 0, want);
    else chk(name, runs.pop_front(), want);
  endtask

  // Monitor: pops one expected word per valid output and tracks valid run lengths.
  initial begin
    exp_t e;
    int   run_len;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (bus0.out_valid) begin
        run_len++;
        $display("out ch=%0d first=%0d lane0=%0d lane1=%0d", bus0.out_ch, bus0.out_first,
                 bus0.data_out[0], bus0.data_out[1]);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lane0", int'(bus0.data_out[0]), e.l0);
          chk("lane1", int'(bus0.data_out[1]), e.l1);
          chk("out_ch", int'(bus0.out_ch), e.ch);
          chk("out_first", int'(bus0.out_first), e.first);
        end
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.data_in[0] = '0; bus0.data_in[1] = '0;
    bus1.in_valid = 1'b0; bus1.data_in[0] = '0;
    bus2.in_valid = 1'b0; bus2.data_in[0] = '0;

    @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus0.out_valid), 0);
    chk("rst_data0", int'(bus0.data_out[0]), 0);
    chk("rst_first", int'(bus0.out_first), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single block, with latency probe
    send_block(0, 1'b0, 30, 1'b1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("lat_not_yet", int'(bus0.out_valid), 0);
    @(negedge clk); #1;
    chk("lat_two", int'(bus0.out_valid), 1);
    drain();
    chk_run("run_t1", 30);

    // 2: two blocks at full rate, then again with a tagged second block
    send_block(0, 1'b0, 30, 1'b1);
    send_block(0, 1'b0, 30, 1'b1);
    drain();
    chk_run("run_t2", 60);
    send_block(0, 1'b0, 30, 1'b1);
    send_block(128, 1'b0, 30, 1'b1);
    drain();
    chk_run("run_t2b", 60);

    // 3: in_valid toggling
    send_block(0, 1'b1, 30, 1'b1);
    drain();
    chk_run("run_t3", 30);
    chk("hold_lane0", int'(bus0.data_out[0]), 41);
    chk("hold_lane1", int'(bus0.data_out[1]), 214);

    // 4: reset after a partial block
    send_block(0, 1'b0, 15, 1'b0);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(bus0.out_valid), 0);
    chk("rst_mid_data0", int'(bus0.data_out[0]), 0);
    chk("rst_mid_data1", int'(bus0.data_out[1]), 0);
    chk("rst_mid_ch", int'(bus0.out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_block(0, 1'b0, 30, 1'b1);
    drain();
    chk_run("run_t4", 30);
    chk("runs_extra", runs.size(), 0);

    // 6: degenerate geometries, order preserved with latency 2
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.data_in[0] = 8'(80 + i);
      bus2.in_valid = 1'b1; bus2.data_in[0] = 8'(80 + i);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("sw1_not_yet", int'(bus1.out_valid), 0);
    chk("sw2_not_yet", int'(bus2.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      $display("sweep i=%0d a=%0d/%0d b=%0d/%0d", i, bus1.data_out[0], bus1.out_ch,
               bus2.data_out[0], bus2.out_ch);
      chk("sw1_valid", int'(bus1.out_valid), 1);
      chk("sw1_data", int'(bus1.data_out[0]), 80 + i);
      chk("sw1_ch", int'(bus1.out_ch), 0);
      chk("sw1_first", int'(bus1.out_first), (i == 0) ? 1 : 0);
      chk("sw2_valid", int'(bus2.out_valid), 1);
      chk("sw2_data", int'(bus2.data_out[0]), 80 + i);
      chk("sw2_ch", int'(bus2.out_ch), i);
      chk("sw2_first", int'(bus2.out_first), (i == 0) ? 1 : 0);
    end
    @(negedge clk); #1;
    chk("sw1_end", int'(bus1.out_valid), 0);
    chk("sw2_end", int'(bus2.out_valid), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interleave_block_input_vector.md
Name: interleave_block_input_vector

Overview:
- Upstream neighbour of the block deinterleaver: turns block-ordered samples into a sample-interleaved stream for that stage.
- Block order in: N consecutive samples of channel 0, then N of channel 1, … up to channel IIR-1.
- Interleaved order out: ch0 s0, ch1 s0, … chIIR-1 s0, ch0 s1, …
- V lanes run in lockstep. Buffering is a per-lane ping-pong RAM of 2×IIR×N words, with counters shared across lanes.

Parameters:
- BITS, 8, sample width per lane
- IIR, 3, number of interleaved channels (≥1)
- N, 10, samples per channel per block (≥1)
- V, 2, number of parallel lanes (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data_in holds one block-ordered sample per lane this cycle
- data_in[V]  input  BITS each  input samples, one per lane
- out_valid  output  1  data_out, out_ch and out_first are valid
- data_out[V]  output  BITS each  interleaved output samples
- out_ch  output  $clog2(IIR) (min 1)  channel index of the current output
- out_first  output  1  high on the first output of each block (ch0, s0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low):
  - out_valid, out_first, out_ch and data_out all go to 0 immediately.
  - Write counters w_idx, w_ch and write bank wb clear to 0.
  - Both banks are marked empty and the reader returns to IDLE.
- Reset mid-block: the partial block is discarded. The first sample accepted after reset is ch0 s0 of bank 0.
- Write side:
  - Each in_valid cycle writes data_in to address wb×DEPTH + w_ch×N + w_idx, where DEPTH = IIR×N.
  - w_idx counts 0..N-1 and wraps, then w_ch increments.
  - After w_ch = IIR-1 and w_idx = N-1 the bank is complete: full[wb] is set, wb toggles, and the counters clear.
  - Gaps in in_valid are allowed; the counters simply hold.
- Read state machine, IDLE ↔ READ:
  - IDLE → READ when any bank is full, taking bank rb.
  - In READ, the read address is rb×DEPTH + r_ch×N + r_idx. r_ch counts fastest (0..IIR-1), then r_idx (0..N-1).
  - After the read of (IIR-1, N-1): clear full[rb] and toggle rb. Go straight to READ if the other bank is full, else IDLE.
- RAM timing: synchronous read with 1-cycle latency. out_valid, out_ch and out_first are pipelined one stage to align with data_out.
- Latency: the first output of a block appears 2 clocks after the edge that captured the block's last input.
- Output rate: within a block, out_valid is continuous for exactly IIR×N cycles with no gaps.
- Back-to-back blocks at full input rate must give a continuous out_valid with no bubble.
- Simultaneous events:
  - Setting full for one bank and clearing full for the other in the same cycle are independent.
  - A set and clear on the same bank cannot occur.
- Overflow: structurally impossible, because the read rate equals the maximum write rate. An assertion checks that the writer never starts a bank whose full flag is still set.
- IIR=1 or N=1 are legal degenerate cases: output order equals input order, same latency.
- data_out holds its last value when out_valid is low.

Decomposition:
- Shared package interleave_pkg, holding:
  - localparams DEPTH = IIR×N and AW = $clog2(2×DEPTH);
  - the state enum {IDLE, READ};
  - function addr_of(bank, ch, idx).
- Counters, full flags and the FSM are instantiated once in the top level.
- One sub-module, simple_dual_port_ram (BITS wide, 2×DEPTH deep, registered read), instantiated V times under a generate loop.

Test Plan (IIR=3, N=10, V=2, BITS=8; lane0 input = ch×16+idx, lane1 = ~lane0):
1. One block, in_valid continuous for 30 cycles:
   - lane0 out = 0,16,32,1,17,33,…,9,25,41;
   - out_ch cycles 0,1,2;
   - out_first high only on the first output;
   - first out_valid 2 cycles after the last input.
2. Two blocks back-to-back at full rate (60 inputs) → 60 consecutive out_valid cycles with no bubble; the second block starts with 0 and out_first=1.
3. in_valid toggling 1/0 for one block → no output until all 30 samples are captured, then 30 contiguous outputs in the same order as test 1.
4. Reset asserted after 15 inputs, then a fresh block of 30:
   - outputs drop to 0 immediately on reset;
   - the discarded partial block never appears;
   - the fresh block's output matches test 1.
5. Lane check → lane1 out = ~lane0 out on every out_valid cycle.
6. Parameter sweep IIR=1,N=4 and IIR=4,N=1 → output order equals input order, latency 2.
